// File: rtl/cache_fill_pkg.sv
// Shared types and sizing for the cache block fill reader.
// Sizes a block of WORDS 16-bit words.
package cache_fill_pkg;

  localparam int ADDR_W            = 16;
  localparam int DATA_W            = 16;
  localparam int WORDS             = 8;
  localparam int OFFSET_W          = $clog2(WORDS);
  localparam int BLOCK_OFFSET_BITS = $clog2(2 * WORDS);

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and count enable.
// Used for both the issued-request and received-word counts.
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill reader: issues WORDS back-to-back word reads for the
// missing block and streams returned words into the data/tag arrays.
//
// state | meaning
// IDLE  | waiting for a miss; returning data is ignored
// FILL  | issuing reads and/or collecting returned words for one block
module cache_fill_fsm
  import cache_fill_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_detected,
  input  logic [ADDR_W-1:0]   miss_address,
  input  logic                memory_data_valid,
  input  logic [DATA_W-1:0]   memory_data,
  output logic                fsm_busy,
  output logic                memory_read,
  output logic [ADDR_W-1:0]   memory_address,
  output logic                write_data_array,
  output logic [OFFSET_W-1:0] fill_offset,
  output logic [DATA_W-1:0]   fill_data,
  output logic                write_tag_array
);

  localparam logic [OFFSET_W:0] LAST_WORD = (OFFSET_W + 1)'(WORDS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [OFFSET_W:0]   issue_cnt, recv_cnt;
  logic [ADDR_W-1:0]   issue_byte;
  logic                accept;
  logic                cnt_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q <= miss_address & BLOCK_MASK;
      end
    end
  end

  // Word index to byte offset; base is block-aligned so this never carries out.
  assign issue_byte = {{(ADDR_W - OFFSET_W - 1){1'b0}}, issue_cnt[OFFSET_W-1:0], 1'b0};

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = base_q;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          accept  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_cnt[OFFSET_W]) begin
          memory_read    = 1'b1;
          memory_address = base_q + issue_byte;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          if (recv_cnt == LAST_WORD) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_clr     = rst | accept;
  assign fill_offset = recv_cnt[OFFSET_W-1:0];
  assign fill_data   = memory_data;

  fill_counter #(.W(OFFSET_W + 1)) u_issue_cnt (
    .clk (clk),
    .rst (cnt_clr),
    .en  (memory_read),
    .cnt (issue_cnt)
  );

  fill_counter #(.W(OFFSET_W + 1)) u_recv_cnt (
    .clk (clk),
    .rst (cnt_clr),
    .en  (write_data_array),
    .cnt (recv_cnt)
  );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: latency-4 memory model plus expected-address and
// expected-write scoreboards filled when each miss is driven.
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_offset;
  logic [15:0] fill_data;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_offset       (fill_offset),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  off;
    logic [15:0] data;
    logic        tag;
  } wr_t;

  logic [15:0] exp_addr_q[$];
  wr_t         exp_wr_q[$];

  logic        pipe_v[8];
  logic [15:0] pipe_d[8];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic m_busy   = 1'b0;
  int   m_issue  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input logic r, input logic miss, input logic [15:0] maddr,
                       input logic stray_v, input logic [15:0] stray_d);
    int      idx;
    logic    exp_rd, exp_wr, last_tag;
    logic [15:0] base, ea;
    wr_t     e;
    idx = cyc % 8;
    memory_data_valid = pipe_v[idx] | stray_v;
    memory_data       = pipe_v[idx] ? pipe_d[idx] : stray_d;
    pipe_v[idx]       = 1'b0;
    rst               = r;
    miss_detected     = miss;
    miss_address      = maddr;
    #1;
    last_tag = 1'b0;
    check("busy", 32'(fsm_busy), 32'(m_busy));
    exp_rd = m_busy && (m_issue < 8);
    check("read", 32'(memory_read), 32'(exp_rd));
    if (exp_rd) begin
      if (exp_addr_q.size() == 0) check("addr_q_underflow", 32'(1), 32'(0));
      else begin
        ea = exp_addr_q.pop_front();
        check("addr", 32'(memory_address), 32'(ea));
      end
      m_issue++;
      pipe_v[(cyc + LAT) % 8] = 1'b1;
      pipe_d[(cyc + LAT) % 8] = 16'hA000 | 16'((memory_address >> 1) & 16'h7);
    end
    exp_wr = m_busy && memory_data_valid;
    check("write", 32'(write_data_array), 32'(exp_wr));
    if (exp_wr) begin
      if (exp_wr_q.size() == 0) check("wr_q_underflow", 32'(1), 32'(0));
      else begin
        e = exp_wr_q.pop_front();
        check("offset", 32'(fill_offset), 32'(e.off));
        check("data", 32'(fill_data), 32'(e.data));
        check("tag", 32'(write_tag_array), 32'(e.tag));
        last_tag = e.tag;
      end
    end else begin
      check("tag_idle", 32'(write_tag_array), 32'(0));
    end
    if (r) begin
      m_busy  = 1'b0;
      m_issue = 0;
      exp_addr_q.delete();
      exp_wr_q.delete();
    end else if (!m_busy && miss) begin
      m_busy  = 1'b1;
      m_issue = 0;
      base    = maddr & 16'hFFF0;
      for (int i = 0; i < 8; i++) begin
        exp_addr_q.push_back(base + 16'(2 * i));
        exp_wr_q.push_back('{off: 3'(i), data: 16'hA000 | 16'(i), tag: (i == 7)});
      end
    end else if (m_busy && last_tag) begin
      m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic fill(input logic [15:0] a);
    cycle(1'b0, 1'b1, a, 1'b0, 16'h0);
    idle(13);
    check("scoreboard_drained", 32'(exp_addr_q.size() + exp_wr_q.size()), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = 16'h0;
    end
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(fsm_busy), 32'(0));
    check("rst_read", 32'(memory_read), 32'(0));
    check("rst_addr", 32'(memory_address), 32'(0));
    check("rst_write", 32'(write_data_array), 32'(0));
    check("rst_offset", 32'(fill_offset), 32'(0));
    check("rst_tag", 32'(write_tag_array), 32'(0));
    @(posedge clk);
    #1;

    fill(16'h1234);
    fill(16'hFFFE);

    // Miss held high through the whole fill; re-accepted right after the tag write.
    cycle(1'b0, 1'b1, 16'h2000, 1'b0, 16'h0);
    repeat (12) cycle(1'b0, 1'b1, 16'h4000, 1'b0, 16'h0);
    check("b2b_busy_at_tag_cycle_end", 32'(m_busy), 32'(0));
    fill(16'h4000);

    // Stray returns while idle must not write.
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'hDEAD);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'hDEAD);
    fill(16'h3000);

    // Reset after the third returned word, let in-flight returns drain, refill.
    cycle(1'b0, 1'b1, 16'h5000, 1'b0, 16'h0);
    idle(7);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(6);
    fill(16'h0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
